// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the write/read client ports and the SDRAM controller host port.
// The arbiter takes the slave view; clients plus controller take the master view.
interface sdram_port_arbiter_if #(
    parameter int HADDR_WIDTH = 27,
    parameter int DATA_WIDTH  = 16
);
    logic                   wr_req;
    logic [HADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   wr_ack;
    logic                   rd_req;
    logic [HADDR_WIDTH-1:0] rd_addr;
    logic                   rd_ack;
    logic [DATA_WIDTH-1:0]  rd_rdata;
    logic [HADDR_WIDTH-1:0] sd_wr_addr;
    logic [DATA_WIDTH-1:0]  sd_wr_data;
    logic                   sd_wr_enable;
    logic [HADDR_WIDTH-1:0] sd_rd_addr;
    logic                   sd_rd_enable;
    logic [DATA_WIDTH-1:0]  sd_rd_data;
    logic                   sd_rd_ready;
    logic                   sd_busy;

    modport master (
        output wr_req, wr_addr, wr_data,
        output rd_req, rd_addr,
        output sd_rd_data, sd_rd_ready, sd_busy,
        input  wr_ack, rd_ack, rd_rdata,
        input  sd_wr_addr, sd_wr_data, sd_wr_enable,
        input  sd_rd_addr, sd_rd_enable
    );

    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  rd_req, rd_addr,
        input  sd_rd_data, sd_rd_ready, sd_busy,
        output wr_ack, rd_ack, rd_rdata,
        output sd_wr_addr, sd_wr_data, sd_wr_enable,
        output sd_rd_addr, sd_rd_enable
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares the single-word SDRAM host port between a write client and a read client,
// with write-priority or round-robin arbitration and a consecutive-grant cap.
module sdram_port_arbiter #(
    parameter int HADDR_WIDTH = 27,
    parameter int DATA_WIDTH  = 16,
    parameter bit WR_PRIORITY = 1'b1,
    parameter int MAX_CONSEC  = 8
) (
    input logic clk,
    input logic rst_n,
    sdram_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_CONSEC + 1);

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT
    } state_t;

    state_t                 state;
    logic                   last_rd;
    logic [CW-1:0]          consec;
    logic                   wr_ack_q;
    logic                   rd_ack_q;
    logic [DATA_WIDTH-1:0]  rd_rdata_q;
    logic [HADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic                   wr_en_q;
    logic [HADDR_WIDTH-1:0] rd_addr_q;
    logic                   rd_en_q;

    logic          both;
    logic          gnt_wr;
    logic          gnt_rd;
    logic          same;
    logic [CW-1:0] consec_nxt;

    assign both = bus.wr_req && bus.rd_req;

    // The ack cycle is a dead arbitration cycle: the acked client's req is
    // stale there, and holding off both ports keeps back-to-back streams fair.
    always_comb begin
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (!(wr_ack_q || rd_ack_q)) begin
            if (both) begin
                if (consec == CW'(MAX_CONSEC) || !WR_PRIORITY)
                    gnt_wr = last_rd;
                else
                    gnt_wr = 1'b1;
                gnt_rd = !gnt_wr;
            end else begin
                gnt_wr = bus.wr_req;
                gnt_rd = bus.rd_req;
            end
        end
    end

    always_comb begin
        same = gnt_wr ? !last_rd : last_rd;
        if (same && both)
            consec_nxt = (consec == CW'(MAX_CONSEC)) ? consec : consec + 1'b1;
        else
            consec_nxt = CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_rd    <= 1'b1;
            consec     <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_rdata_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
        end else begin
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_wr) begin
                        wr_addr_q <= bus.wr_addr;
                        wr_data_q <= bus.wr_data;
                        wr_en_q   <= 1'b1;
                        last_rd   <= 1'b0;
                        consec    <= consec_nxt;
                        state     <= WR_ISSUE;
                    end else if (gnt_rd) begin
                        rd_addr_q <= bus.rd_addr;
                        rd_en_q   <= 1'b1;
                        last_rd   <= 1'b1;
                        consec    <= consec_nxt;
                        state     <= RD_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (bus.sd_busy) begin
                        wr_en_q <= 1'b0;
                        state   <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (!bus.sd_busy) begin
                        wr_ack_q <= 1'b1;
                        state    <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    if (bus.sd_busy) begin
                        rd_en_q <= 1'b0;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.sd_rd_ready) begin
                        rd_rdata_q <= bus.sd_rd_data;
                        rd_ack_q   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wr_ack       = wr_ack_q;
    assign bus.rd_ack       = rd_ack_q;
    assign bus.rd_rdata     = rd_rdata_q;
    assign bus.sd_wr_addr   = wr_addr_q;
    assign bus.sd_wr_data   = wr_data_q;
    assign bus.sd_wr_enable = wr_en_q;
    assign bus.sd_rd_addr   = rd_addr_q;
    assign bus.sd_rd_enable = rd_en_q;
endmodule
